// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the fetched instruction/npc and the execute, memory and writeback control words.
// One-cycle latency; enable_decode=0 holds every output except decode_valid, so stalls of any length are safe.
module lc3_decode #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_decode,
  input  logic [DW-1:0] dout,
  input  logic [DW-1:0] npc_in,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] npc_out,
  output logic [5:0]    e_control,
  output logic [1:0]    w_control,
  output logic          mem_control,
  output logic          illegal,
  output logic          decode_valid
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_ZERO = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  logic [3:0]    opcode;
  logic [1:0]    dec_alu;
  logic [1:0]    dec_pcsel1;
  logic          dec_pcsel2;
  logic          dec_op2;
  logic [1:0]    dec_wb;
  logic          dec_mem;
  logic          dec_ill;

  logic [DW-1:0] ir_q,        ir_d;
  logic [DW-1:0] npc_q,       npc_d;
  logic [5:0]    e_ctrl_q,    e_ctrl_d;
  logic [1:0]    w_ctrl_q,    w_ctrl_d;
  logic          mem_ctrl_q,  mem_ctrl_d;
  logic          illegal_q,   illegal_d;
  logic          valid_q,     valid_d;

  assign opcode = dout[DW-1 -: 4];

  always_comb begin
    dec_alu    = 2'b00;
    dec_pcsel1 = PC1_NONE;
    dec_pcsel2 = 1'b0;
    dec_op2    = 1'b0;
    dec_wb     = WB_ALU;
    dec_mem    = 1'b0;
    dec_ill    = 1'b0;
    case (opcode)
      OP_ADD: dec_op2 = ~dout[5];
      OP_AND: begin
        dec_alu = 2'b01;
        dec_op2 = ~dout[5];
      end
      OP_NOT: dec_alu = 2'b10;
      OP_BR, OP_ST: begin
        dec_pcsel1 = PC1_OFF9;
        dec_pcsel2 = 1'b1;
      end
      OP_LD: begin
        dec_pcsel1 = PC1_OFF9;
        dec_pcsel2 = 1'b1;
        dec_wb     = WB_MEM;
      end
      OP_LDI: begin
        dec_pcsel1 = PC1_OFF9;
        dec_pcsel2 = 1'b1;
        dec_wb     = WB_MEM;
        dec_mem    = 1'b1;
      end
      OP_STI: begin
        dec_pcsel1 = PC1_OFF9;
        dec_pcsel2 = 1'b1;
        dec_mem    = 1'b1;
      end
      OP_LEA: begin
        dec_pcsel1 = PC1_OFF9;
        dec_pcsel2 = 1'b1;
        dec_wb     = WB_PC;
      end
      OP_LDR: begin
        dec_pcsel1 = PC1_OFF6;
        dec_wb     = WB_MEM;
      end
      OP_STR: dec_pcsel1 = PC1_OFF6;
      OP_JMP: dec_pcsel1 = PC1_ZERO;
      // Reserved opcodes leave every control field at zero so downstream stages see a no-op.
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    npc_d      = npc_q;
    e_ctrl_d   = e_ctrl_q;
    w_ctrl_d   = w_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    illegal_d  = illegal_q;
    valid_d    = enable_decode;
    if (enable_decode) begin
      ir_d       = dout;
      npc_d      = npc_in;
      e_ctrl_d   = {dec_alu, dec_pcsel1, dec_pcsel2, dec_op2};
      w_ctrl_d   = dec_wb;
      mem_ctrl_d = dec_mem;
      illegal_d  = dec_ill;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q       <= '0;
      npc_q      <= '0;
      e_ctrl_q   <= '0;
      w_ctrl_q   <= '0;
      mem_ctrl_q <= 1'b0;
      illegal_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      npc_q      <= npc_d;
      e_ctrl_q   <= e_ctrl_d;
      w_ctrl_q   <= w_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      illegal_q  <= illegal_d;
      valid_q    <= valid_d;
    end
  end

  assign ir           = ir_q;
  assign npc_out      = npc_q;
  assign e_control    = e_ctrl_q;
  assign w_control    = w_ctrl_q;
  assign mem_control  = mem_ctrl_q;
  assign illegal      = illegal_q;
  assign decode_valid = valid_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Bench for lc3_decode: directed ISA cases plus a randomized run against an opcode-table reference model.
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_decode = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] ir;
  logic [15:0] npc_out;
  logic [5:0]  e_control;
  logic [1:0]  w_control;
  logic        mem_control;
  logic        illegal;
  logic        decode_valid;

  int checks = 0;
  int errors = 0;

  // Expected registered state, maintained by the bench's own model.
  logic [15:0] exp_ir, exp_npc;
  logic [5:0]  exp_e;
  logic [1:0]  exp_w;
  logic        exp_m, exp_ill, exp_vld;

  lc3_decode #(.DW(16)) dut (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in), .ir(ir), .npc_out(npc_out),
    .e_control(e_control), .w_control(w_control), .mem_control(mem_control),
    .illegal(illegal), .decode_valid(decode_valid)
  );

  always #5 clock = ~clock;

  // Returns {illegal, mem_control, w_control[1:0], e_control[5:0]} from the ISA tables.
  function automatic logic [9:0] ref_ctrl(input logic [15:0] word);
    int op;
    logic ill, mem, off9, off6, jmp, op2;
    logic [1:0] alu, pcs1, wb;
    op   = int'(word[15:12]);
    ill  = op inside {4, 8, 13, 15};
    if (ill) return {1'b1, 9'b0};
    alu  = (op == 5) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    off9 = op inside {0, 2, 3, 10, 11, 14};
    off6 = op inside {6, 7};
    jmp  = (op == 12);
    pcs1 = off9 ? 2'd1 : off6 ? 2'd2 : jmp ? 2'd3 : 2'd0;
    op2  = (op inside {1, 5}) && !word[5];
    wb   = (op inside {2, 6, 10}) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
    mem  = op inside {10, 11};
    return {1'b0, mem, wb, alu, pcs1, off9, op2};
  endfunction

  task automatic model_reset();
    exp_ir = '0; exp_npc = '0; exp_e = '0; exp_w = '0;
    exp_m = 1'b0; exp_ill = 1'b0; exp_vld = 1'b0;
  endtask

  // Drive on the falling edge, take one rising edge, update the model, sample 1 time unit later.
  task automatic step(input logic en, input logic [15:0] word, input logic [15:0] npc);
    logic [9:0] c;
    @(negedge clock);
    enable_decode = en;
    dout = word;
    npc_in = npc;
    @(posedge clock);
    exp_vld = en;
    if (en) begin
      c = ref_ctrl(word);
      exp_ir = word; exp_npc = npc;
      {exp_ill, exp_m, exp_w, exp_e} = c;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({ir, npc_out, e_control, w_control, mem_control, illegal, decode_valid} !== '0) begin
      errors++;
      $display("FAIL reset_initial: ir=%h npc=%h e=%b w=%b m=%b ill=%b vld=%b, required all 0",
               ir, npc_out, e_control, w_control, mem_control, illegal, decode_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 16'h1283, 16'h3000);
    checks++;
    if (ir !== 16'h1283) begin
      errors++;
      $display("FAIL reset_pre_capture: ir=%h required 1283", ir);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ir, npc_out, e_control, w_control, mem_control, illegal, decode_valid} !== '0) begin
      errors++;
      $display("FAIL reset_async: ir=%h npc=%h e=%b w=%b m=%b ill=%b vld=%b, required all 0",
               ir, npc_out, e_control, w_control, mem_control, illegal, decode_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 16'h5260, 16'h3001);
    checks++;
    if (ir !== 16'h5260 || decode_valid !== 1'b1 || npc_out !== 16'h3001) begin
      errors++;
      $display("FAIL reset_release: ir=%h vld=%b npc=%h required 5260 1 3001", ir, decode_valid, npc_out);
    end
  endtask

  task automatic test_opcodes();
    // {dout, e_control, w_control, mem_control}
    logic [24:0] tbl [7];
    tbl[0] = {16'h1283, 6'b000001, 2'b00, 1'b0};
    tbl[1] = {16'h5260, 6'b010000, 2'b00, 1'b0};
    tbl[2] = {16'h927F, 6'b100000, 2'b00, 1'b0};
    tbl[3] = {16'h6942, 6'b001000, 2'b01, 1'b0};
    tbl[4] = {16'hB7FF, 6'b000110, 2'b00, 1'b1};
    tbl[5] = {16'hE005, 6'b000110, 2'b10, 1'b0};
    tbl[6] = {16'hC1C0, 6'b001100, 2'b00, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, tbl[i][24:9], 16'h4000 + 16'(i));
      checks++;
      if ({ir, e_control, w_control, mem_control} !== tbl[i] || illegal !== 1'b0) begin
        errors++;
        $display("FAIL opcode_%0d: ir=%h e=%b w=%b m=%b ill=%b, required ir=%h e=%b w=%b m=%b ill=0",
                 i, ir, e_control, w_control, mem_control, illegal,
                 tbl[i][24:9], tbl[i][8:3], tbl[i][2:1], tbl[i][0]);
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 16'h2005, 16'h3001);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h1283, 16'h5555);
      checks++;
      if (ir !== 16'h2005 || npc_out !== 16'h3001 || decode_valid !== 1'b0 ||
          e_control !== 6'b000110 || w_control !== 2'b01) begin
        errors++;
        $display("FAIL stall_%0d: ir=%h npc=%h vld=%b e=%b w=%b, required 2005 3001 0 000110 01",
                 i, ir, npc_out, decode_valid, e_control, w_control);
      end
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 16'hF025, 16'h3100);
    checks++;
    if (illegal !== 1'b1 || ir !== 16'hF025 || e_control !== '0 || w_control !== '0 || mem_control !== 1'b0) begin
      errors++;
      $display("FAIL illegal_F025: ill=%b ir=%h e=%b w=%b m=%b, required 1 F025 0 0 0",
               illegal, ir, e_control, w_control, mem_control);
    end
    step(1'b1, 16'h0402, 16'h3101);
    checks++;
    if (illegal !== 1'b0 || e_control !== 6'b000110) begin
      errors++;
      $display("FAIL illegal_recover: ill=%b e=%b, required 0 000110", illegal, e_control);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'h1283, 16'hFFFF);
    checks++;
    if (npc_out !== 16'hFFFF || ir !== 16'h1283) begin
      errors++;
      $display("FAIL pair_ffff: npc=%h ir=%h, required FFFF 1283", npc_out, ir);
    end
    step(1'b1, 16'h6942, 16'h0000);
    checks++;
    if (npc_out !== 16'h0000 || ir !== 16'h6942) begin
      errors++;
      $display("FAIL pair_0000: npc=%h ir=%h, required 0000 6942", npc_out, ir);
    end
  endtask

  task automatic test_random();
    logic en;
    logic [15:0] w, n;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      w  = 16'($urandom);
      n  = 16'($urandom);
      step(en, w, n);
      checks++;
      if ({ir, npc_out, e_control, w_control, mem_control, illegal, decode_valid} !==
          {exp_ir, exp_npc, exp_e, exp_w, exp_m, exp_ill, exp_vld}) begin
        errors++;
        $display("FAIL random_%0d: ir=%h npc=%h e=%b w=%b m=%b ill=%b vld=%b, required ir=%h npc=%h e=%b w=%b m=%b ill=%b vld=%b",
                 i, ir, npc_out, e_control, w_control, mem_control, illegal, decode_valid,
                 exp_ir, exp_npc, exp_e, exp_w, exp_m, exp_ill, exp_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_decode.md
# lc3_decode

Instruction decode stage of the 16-bit LC-3-style pipeline, sitting directly downstream of the fetch stage. It registers the instruction word returned by instruction memory (read under fetch's `imem_rd`) together with fetch's `npc`. It then produces the per-stage control words consumed by execute, memory and writeback. Outputs are registered, so decode holds its contents when the pipeline stalls.

## Interface
Parameters:
- `DW`, 16: instruction/PC width; fixed at 16 for this ISA.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable_decode`  in  1  capture enable; 0 = stall/hold.
- `dout`  in  16  instruction word from instruction memory.
- `npc_in`  in  16  fetch `npc` (PC+1) paired with `dout`.
- `ir`  out  16  registered instruction.
- `npc_out`  out  16  registered `npc_in`.
- `e_control`  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `w_control`  out  2  writeback mux select.
- `mem_control`  out  1  1 = indirect memory access (LDI/STI).
- `illegal`  out  1  unsupported opcode captured.
- `decode_valid`  out  1  registered copy of `enable_decode`.

## Operation
- Opcode = `dout[15:12]`. All control is decoded combinationally from `dout` and registered.
- alu_control:
  - ADD(0001) = 00
  - AND(0101) = 01
  - NOT(1001) = 10
  - all others = 00
- pcselect1 (offset select):
  - BR(0000), LD(0010), ST(0011), LDI(1010), STI(1011), LEA(1110) = 01 (sext offset9)
  - LDR(0110), STR(0111) = 10 (sext offset6)
  - JMP(1100) = 11 (zero offset)
  - ALU ops = 00
- pcselect2 (base select):
  - 1 (npc base) for BR/LD/ST/LDI/STI/LEA
  - 0 otherwise (BaseR)
- op2select:
  - ADD/AND: `~dout[5]` (1 = register, 0 = imm5)
  - all others: 0
- w_control:
  - ADD/AND/NOT = 00 (ALU)
  - LD/LDR/LDI = 01 (memory)
  - LEA = 10 (pc-relative address)
  - all others = 00
- mem_control = 1 only for LDI/STI.
- Illegal opcodes 0100, 1000, 1101, 1111:
  - `illegal` = 1
  - e_control, w_control, mem_control forced to 0
  - `ir`/`npc_out` still captured
- Legal opcodes set `illegal` = 0.

## Timing
- Reset (`reset` = 0) takes effect immediately, independent of `clock`. `ir`, `npc_out`, `e_control`, `w_control`, `mem_control`, `illegal` and `decode_valid` all go to 0.
- Reset asserted mid-operation discards the captured instruction. First capture occurs at the first rising edge with `reset` = 1 and `enable_decode` = 1.
- Latency 1 cycle: values of `dout`/`npc_in` sampled at edge N appear on outputs after edge N.
- `enable_decode` = 0 at an edge: every output except `decode_valid` holds its value. Stalls of any length are permitted.
- `decode_valid` updates every edge to the sampled `enable_decode` value. It is 0 in the cycle after a stall edge, even though the held data persists.
- `ir` and control outputs always come from the same sampled `dout`; no mixed-cycle outputs.
- `npc_out` is copied verbatim. `npc_in` = 0xFFFF passes unchanged (no arithmetic in this stage).

## Test plan
- Reset:
  - Stimulus: drive `reset` = 0 mid-cycle with `ir` = 0x1283.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset with `enable_decode` = 1 and `dout` = 0x5260.
  - Required: `ir` = 0x5260 and `decode_valid` = 1 one edge later.
- ALU ops:
  - ADD R1,R2,R3, `dout` = 0x1283 → `e_control` = 000001, `w_control` = 00, `mem_control` = 0.
  - AND R1,R1,#0, `dout` = 0x5260 → `e_control` = 010000.
  - NOT, `dout` = 0x927F → `e_control` = 100000.
- Memory ops:
  - LDR, `dout` = 0x6942 → `e_control` = 001000, `w_control` = 01.
  - STI, `dout` = 0xB7FF → `e_control` = 000110, `mem_control` = 1.
  - LEA, `dout` = 0xE005 → `e_control` = 000110, `w_control` = 10.
  - JMP R7, `dout` = 0xC1C0 → `e_control` = 001100.
- Stall:
  - Stimulus: `dout` = 0x2005, `npc_in` = 0x3001 captured, then `enable_decode` = 0 for 3 edges while `dout` changes to 0x1283.
  - Required: `ir` = 0x2005 and `npc_out` = 0x3001 held for all 3 cycles; `decode_valid` = 0 during the hold.
- Illegal:
  - Stimulus: `dout` = 0xF025.
  - Required: `illegal` = 1, `ir` = 0xF025, all control = 0.
  - Stimulus: next legal word 0x0402.
  - Required: `illegal` = 0, `e_control` = 000110.
- Pairing:
  - Stimulus: back-to-back captures with `npc_in` = 0xFFFF, then 0x0000.
  - Required: `npc_out` tracks each value with exactly 1-cycle latency, aligned with its `ir`.
